// File: rtl/if_id_buf.sv
// Fetch-to-decode stage register: a small FIFO of {inst_addr, inst} beats
// under valid/ready on both sides, cleared by a pipeline flush.
module if_id_buf #(
  parameter int          DEPTH    = 2,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] inst_i,
  input  logic [31:0] inst_addr_i,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  input  logic        flush_i,
  output logic [31:0] inst_o,
  output logic [31:0] inst_addr_o,
  output logic        out_valid_o,
  input  logic        out_ready_i
);

  localparam int          AW   = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  // Handshake: a beat transfers on a rising edge where valid and ready are
  // both high and flush_i is low; ready never depends on the partner's valid.
  logic [AW:0]   count;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [63:0]   mem [DEPTH];
  logic          push;
  logic          pop;

  // Both flags come from count alone, so there is no out_ready_i -> in_ready_o path.
  assign in_ready_o  = (count != FULL);
  assign out_valid_o = (count != '0);
  assign push        = in_valid_i & in_ready_o & ~flush_i;
  assign pop         = out_valid_o & out_ready_i & ~flush_i;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush_i) begin
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      count <= count + (AW+1)'(1);
      else if (pop && !push) count <= count - (AW+1)'(1);
    end
  end

  // Storage is never cleared; validity is tracked only by count.
  always_ff @(posedge clk) begin
    if (rst_n && push) mem[wr_ptr] <= {inst_addr_i, inst_i};
  end

  always_comb begin
    inst_o      = NOP_INST;
    inst_addr_o = 32'h0;
    if (out_valid_o) begin
      inst_addr_o = mem[rd_ptr][63:32];
      inst_o      = mem[rd_ptr][31:0];
    end
  end

endmodule

// File: tb/tb_if_id_buf.sv
// Bench for if_id_buf: directed scenarios plus a random phase, with a queue
// model of buffer contents checked against the outputs every cycle.
module tb_if_id_buf;
  localparam int          DEPTH = 2;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic        clk;
  logic        rst_n;
  logic [31:0] inst_i;
  logic [31:0] inst_addr_i;
  logic        in_valid_i;
  logic        in_ready_o;
  logic        flush_i;
  logic [31:0] inst_o;
  logic [31:0] inst_addr_o;
  logic        out_valid_o;
  logic        out_ready_i;

  int errors = 0;
  int checks = 0;
  int pops   = 0;
  bit chk_en = 0;
  bit rand_done;
  logic [63:0] exp_q[$];

  if_id_buf #(.DEPTH(DEPTH), .NOP_INST(NOP)) dut (
    .clk(clk), .rst_n(rst_n), .inst_i(inst_i), .inst_addr_i(inst_addr_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .flush_i(flush_i),
    .inst_o(inst_o), .inst_addr_o(inst_addr_o), .out_valid_o(out_valid_o),
    .out_ready_i(out_ready_i)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive one beat and hold it until the buffer accepts it.
  task automatic send(input logic [31:0] a);
    int   guard;
    logic acc;
    guard       = 0;
    acc         = 1'b0;
    inst_i      = $urandom;
    inst_addr_i = a;
    in_valid_i  = 1'b1;
    do begin
      @(negedge clk);
      acc = in_ready_o && !flush_i && rst_n;
      @(posedge clk);
      #1;
      guard++;
    end while (!acc && guard < 200);
    in_valid_i = 1'b0;
    checks++;
    if (!acc) begin
      errors++;
      $display("FAIL send_timeout: addr %h not accepted in 200 cycles", a);
    end
  endtask

  // Scoreboard: exp_q holds the beats the buffer should contain, oldest first.
  // Outputs are compared before the coming edge, then the model is advanced.
  always @(negedge clk) begin
    if (chk_en) begin
      logic [63:0] head;
      bit          mpush;
      bit          mpop;
      head = (exp_q.size() != 0) ? exp_q[0] : {32'h0, NOP};
      chk("in_ready",  64'(in_ready_o),  64'(exp_q.size() < DEPTH));
      chk("out_valid", 64'(out_valid_o), 64'(exp_q.size() != 0));
      chk("head", {inst_addr_o, inst_o}, head);
      if (!rst_n || flush_i) begin
        exp_q.delete();
      end else begin
        mpop  = (exp_q.size() != 0) && out_ready_i;
        mpush = in_valid_i && (exp_q.size() < DEPTH);
        if (mpop) begin
          void'(exp_q.pop_front());
          pops++;
        end
        if (mpush) exp_q.push_back({inst_addr_i, inst_i});
      end
    end
  end

  initial begin
    int p0;
    rst_n       = 1'b0;
    flush_i     = 1'b0;
    in_valid_i  = 1'b1;
    inst_i      = 32'hdead_beef;
    inst_addr_i = 32'h0000_0100;
    out_ready_i = 1'b1;

    // 1. reset with a beat offered; nothing may leak out afterwards
    step();
    chk_en = 1'b1;
    step();
    in_valid_i = 1'b0;
    rst_n      = 1'b1;
    repeat (2) step();

    // 2. streaming
    p0 = pops;
    send(32'h0);
    send(32'h4);
    send(32'h8);
    repeat (2) step();
    chk("stream_pops", 64'(pops - p0), 64'd3);

    // 3. back-pressure, then release while 0x18 is held off
    out_ready_i = 1'b0;
    send(32'h10);
    send(32'h14);
    fork
      send(32'h18);
      begin
        repeat (3) step();
        out_ready_i = 1'b1;
      end
    join
    repeat (3) step();

    // 4. flush while full with a beat offered
    out_ready_i = 1'b0;
    send(32'h20);
    send(32'h24);
    inst_addr_i = 32'h28;
    inst_i      = $urandom;
    in_valid_i  = 1'b1;
    flush_i     = 1'b1;
    step();
    flush_i     = 1'b0;
    in_valid_i  = 1'b0;
    out_ready_i = 1'b1;
    repeat (3) step();

    // 6. simultaneous push and pop at one entry
    out_ready_i = 1'b0;
    send(32'h30);
    out_ready_i = 1'b1;
    send(32'h34);
    repeat (2) step();

    // 5. random wrap-around with random back-pressure and rare flushes
    rand_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 40; i++) send(32'h1000 + 32'(i) * 4);
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          out_ready_i = 1'($urandom_range(0, 1));
          flush_i     = ($urandom_range(0, 15) == 0);
          step();
        end
        flush_i = 1'b0;
      end
    join
    out_ready_i = 1'b1;
    repeat (4) step();

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule
